sample_tick_receiver: RTL

SAMPLE_TICK_RECEIVER -- requirements
Module: sample_tick_receiver

---
 rtl/sample_rx_pkg.sv | 25 ++
 rtl/sample_tick_receiver_if.sv | 23 ++
 rtl/sync_edge_detect.sv | 38 +++
 rtl/sample_tick_receiver.sv | 139 +++++++++++++
 4 files changed

// File: rtl/sample_rx_pkg.sv
// Shared types and constants for the sample-rate tick receiver.
// Holds the lock FSM encoding and period-counter limits.
package sample_rx_pkg;

  typedef enum logic [1:0] {
    UNLOCKED,
    ACQUIRE,
    LOCKED
  } rx_state_e;

  localparam int CNT_W = 10;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_PRE_MAX = CNT_MAX - 1'b1;

  function automatic logic in_range(
    input logic [CNT_W:0] meas,
    input int             nom,
    input int             tol
  );
    int m;
    m = int'(meas);
    return (m >= nom - tol) && (m <= nom + tol);
  endfunction

endpackage

// File: rtl/sample_tick_receiver_if.sv
// Captured-sample stream towards the downstream FIR.
// Master presents data/valid, slave answers with ready.
interface sample_tick_receiver_if #(
  parameter int DATA_W = 16
);

  logic [DATA_W-1:0] sample_data;
  logic              sample_valid;
  logic              sample_ready;

  modport master (
    output sample_data,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample_data,
    input  sample_valid,
    output sample_ready
  );

endinterface

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer plus registered rising-edge pulse.
// After reset an edge only counts once a low level has been seen.
module sync_edge_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic rise_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic primed_q;
  logic armed_q;
  logic rise_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      prev_q   <= 1'b0;
      primed_q <= 1'b0;
      armed_q  <= 1'b0;
      rise_q   <= 1'b0;
    end else begin
      sync1_q  <= async_i;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      primed_q <= 1'b1;
      // a level held high across reset must not look like a fresh edge
      armed_q  <= armed_q | (primed_q & ~sync1_q);
      rise_q   <= armed_q & sync2_q & ~prev_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/sample_tick_receiver.sv
// Turns the async 48 kHz sample clock into a tick, captures the ADC
// word for the FIR and tracks whether the sample period is locked.
module sample_tick_receiver
  import sample_rx_pkg::*;
#(
  parameter int DATA_W         = 16,
  parameter int NOMINAL_PERIOD = 256,
  parameter int TOL            = 2,
  parameter int LOCK_COUNT     = 4
) (
  input  logic                   clk_audio_12M288,
  input  logic                   rst_n,
  input  logic                   sample_rate_clock,
  input  logic [DATA_W-1:0]      adc_data,
  output logic                   sample_tick,
  sample_tick_receiver_if.master smp,
  output logic                   locked,
  output logic                   period_err,
  output logic                   overrun,
  output logic [CNT_W-1:0]       period_count
);

  localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_COUNT - 1);

  logic              rise;
  logic              tick_q;
  logic [DATA_W-1:0] adc_q;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              ovr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [CNT_W-1:0]  per_q;
  logic [CNT_W:0]    meas;
  logic              meas_ok;
  logic              sat_hit;
  rx_state_e         state_q;
  logic [GOOD_W-1:0] good_q;
  logic              locked_q;
  logic              err_q;

  sync_edge_detect u_sync (
    .clk_i   (clk_audio_12M288),
    .rst_ni  (rst_n),
    .async_i (sample_rate_clock),
    .rise_o  (rise)
  );

  always_comb begin
    meas    = {1'b0, cnt_q} + (CNT_W + 1)'(1);
    meas_ok = in_range(meas, NOMINAL_PERIOD, TOL);
    sat_hit = !tick_q && (cnt_q == CNT_PRE_MAX);
    cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    if (tick_q) cnt_d = '0;
  end

  always_ff @(posedge clk_audio_12M288) begin
    if (!rst_n) begin
      tick_q  <= 1'b0;
      adc_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      tick_q <= rise;
      adc_q  <= adc_data;
      cnt_q  <= cnt_d;
      if (tick_q) begin
        data_q  <= adc_q;
        valid_q <= 1'b1;
        if (valid_q && !smp.sample_ready) ovr_q <= 1'b1;
      end else if (valid_q && smp.sample_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_audio_12M288) begin
    if (!rst_n) begin
      state_q  <= UNLOCKED;
      good_q   <= '0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      per_q    <= '0;
    end else begin
      err_q <= 1'b0;
      if (tick_q) begin
        unique case (state_q)
          UNLOCKED: begin
            state_q <= ACQUIRE;
            good_q  <= '0;
          end
          ACQUIRE: begin
            if (meas_ok) begin
              good_q <= good_q + 1'b1;
              if (good_q == GOOD_LAST) begin
                state_q  <= LOCKED;
                locked_q <= 1'b1;
              end
            end else begin
              good_q <= '0;
              err_q  <= 1'b1;
            end
          end
          LOCKED: begin
            if (!meas_ok) begin
              state_q  <= ACQUIRE;
              locked_q <= 1'b0;
              good_q   <= '0;
              err_q    <= 1'b1;
            end
          end
          default: begin
            state_q  <= UNLOCKED;
            locked_q <= 1'b0;
          end
        endcase
        if (state_q != UNLOCKED) per_q <= meas[CNT_W-1:0];
      end else if (sat_hit && state_q != UNLOCKED) begin
        // only the 1022->1023 step fires, so a parked counter stays quiet
        state_q  <= UNLOCKED;
        locked_q <= 1'b0;
        good_q   <= '0;
        err_q    <= 1'b1;
      end
    end
  end

  assign sample_tick      = tick_q;
  assign smp.sample_data  = data_q;
  assign smp.sample_valid = valid_q;
  assign overrun          = ovr_q;
  assign locked           = locked_q;
  assign period_err       = err_q;
  assign period_count     = per_q;

endmodule
